// File: rtl/alu_pipe.sv
// Elastic pipelined ALU with dual-mode opcode decode,
// valid/ready handshakes and a saturating illegal-op counter.
module alu_pipe #(
  parameter int WIDTH     = 5,
  parameter int STAGES    = 2,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 a_en,
  input  logic                 b_en,
  input  logic [2:0]           a_op,
  input  logic [1:0]           b_op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       C,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int RW = WIDTH + 1;
  localparam logic [RW-1:0] ONE = RW'(1);
  localparam logic [RW-1:0] TWO = RW'(2);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic          v;
    logic          e;
    logic [RW-1:0] c;
  } stg_t;

  logic [RW-1:0]     sa;
  logic [RW-1:0]     sb;
  logic [RW-1:0]     res;
  logic              ill;
  logic [STAGES-1:0] ld;
  stg_t              st [STAGES];
  stg_t              up [STAGES];

  assign sa = {A[WIDTH-1], A};
  assign sb = {B[WIDTH-1], B};

  always_comb begin
    res = '0;
    ill = 1'b0;
    unique case (1'b1)
      (a_en && !b_en): begin
        case (a_op)
          3'd0:      res = sa + sb;
          3'd1:      res = sa - sb;
          3'd2:      res = sa ^ sb;
          3'd3,
          3'd4:      res = sa & sb;
          3'd5:      res = sa | sb;
          3'd6:      res = ~(sa ^ sb);
          default:   ill = 1'b1;
        endcase
      end
      (!a_en && b_en): begin
        case (b_op)
          2'd0:      res = ~(sa & sb);
          2'd1,
          2'd2:      res = sa + sb;
          default:   ill = 1'b1;
        endcase
      end
      (a_en && b_en): begin
        case (b_op)
          2'd0:      res = sa ^ sb;
          2'd1:      res = ~(sa ^ sb);
          2'd2:      res = sa - ONE;
          default:   res = sb + TWO;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) res = '0;
  end

  // Load enables ripple back from the output so bubbles collapse.
  always_comb begin
    logic go;
    go = out_ready;
    ld = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ld[i] = !st[i].v || go;
      go    = ld[i];
    end
  end

  always_comb begin
    up[0] = '{v: in_valid, e: ill, c: res};
    for (int i = 1; i < STAGES; i++) begin
      up[i] = st[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        st[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          st[i].v <= up[i].v;
          if (up[i].v) begin
            st[i].e <= up[i].e;
            st[i].c <= up[i].c;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (in_valid && in_ready && ill) begin
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = st[STAGES-1].v;
  assign C         = st[STAGES-1].c;
  assign err       = st[STAGES-1].e;

endmodule
